mac8_datapath: RTL and testbench

- 8-bit multiply/accumulate datapath for one systolic processing element (PE).
- Combines two functions:
  - a registered 8x8 multiplier whose product is truncated to 8 bits;
  - a registered 8-bit ripple-carry adder that adds the product to an accumulator input and can be frozen by `block`.
- The enclosing PE feeds its previous partial value back on `acc_in` and captures `sum`.

---
 rtl/mac8_datapath.sv | 83 ++++++++
 tb/tb_mac8_datapath.sv | 119 +++++++++++
 2 files changed

// File: rtl/mac8_datapath.sv
// Registered 8x8 truncating multiplier feeding a freezable ripple-carry accumulator adder.
// Define MAC8_DEBUG_EN to compile a simulation trace of each sum update (gated by db).
module mac8_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_in,
  input  logic             block,
  input  logic             db,
  output logic [WIDTH-1:0] prod,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  // Ripple chain with carry-in 0; returns {carry_out, sum}.
  function automatic logic [WIDTH:0] ripple_add(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH:0] r;
    logic [1:0]     cs;
    logic           c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      cs   = full_add(x[i], y[i], c);
      r[i] = cs[0];
      c    = cs[1];
    end
    r[WIDTH] = c;
    return r;
  endfunction

  logic [WIDTH-1:0] pp_row;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH-1:0] prod_next;
  logic [WIDTH:0]   add_next;

  // Shift-and-add of partial products; anything shifted past the top bit is dropped.
  always_comb begin
    prod_next = '0;
    pp_row    = '0;
    acc_step  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pp_row    = (a & {WIDTH{b[i]}}) << i;
      acc_step  = ripple_add(prod_next, pp_row);
      prod_next = acc_step[WIDTH-1:0];
    end
  end

  assign add_next = ripple_add(prod, acc_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      prod <= prod_next;
      if (!block) begin
        sum  <= add_next[WIDTH-1:0];
        cout <= add_next[WIDTH];
      end
    end
  end

`ifdef MAC8_DEBUG_EN
  always_ff @(posedge clk) begin
    if (!rst && !block && db)
      $display("mac8 trace: a=%0d b=%0d acc_in=%0d prod=%0d -> sum=%0d cout=%0b",
               a, b, acc_in, prod, add_next[WIDTH-1:0], add_next[WIDTH]);
  end
`else
  logic unused_db;
  assign unused_db = db;
`endif

endmodule

// File: tb/tb_mac8_datapath.sv
// Directed plus randomized bench for mac8_datapath against an arithmetic reference model.
module tb_mac8_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] a = '0, b = '0, acc_in = '0;
  logic       block = 1'b0, db = 1'b0;
  logic [7:0] prod, sum;
  logic       cout;

  int checks = 0;
  int errors = 0;

  // Reference state: what prod/sum/cout should be after the last edge.
  int m_prod = 0, m_sum = 0, m_cout = 0;

  always #5 clk = ~clk;

  mac8_datapath #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .acc_in(acc_in),
    .block(block), .db(db), .prod(prod), .sum(sum), .cout(cout)
  );

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int ta, input int tb, input int tacc,
                      input bit tblk, input bit trst, input string tag);
    int total;
    a      = ta[7:0];
    b      = tb[7:0];
    acc_in = tacc[7:0];
    block  = tblk;
    rst    = trst;
    db     = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    if (trst) begin
      m_prod = 0; m_sum = 0; m_cout = 0;
    end else begin
      if (!tblk) begin
        total  = m_prod + (tacc % 256);
        m_sum  = total % 256;
        m_cout = (total >= 256) ? 1 : 0;
      end
      m_prod = ((ta % 256) * (tb % 256)) % 256;
    end
    check({tag, ".prod"}, int'(prod), m_prod);
    check({tag, ".sum"},  int'(sum),  m_sum);
    check({tag, ".cout"}, int'(cout), m_cout);
  endtask

  initial begin
    // Reset held two cycles with live operands.
    step(9, 9, 0, 0, 1, "rst0");
    step(9, 9, 0, 0, 1, "rst1");
    check("rst.prod_zero", int'(prod), 0);
    step(9, 9, 0, 0, 0, "rel");
    check("rel.prod81", int'(prod), 81);

    // Basic MAC: 3*5 + 10.
    step(3, 5, 10, 0, 0, "mac1");
    check("mac1.prod15", int'(prod), 15);
    step(3, 5, 10, 0, 0, "mac2");
    check("mac2.sum25", int'(sum), 25);

    // Product truncation.
    step(16, 17, 0, 0, 0, "trunc1");
    check("trunc1.prod16", int'(prod), 16);
    step(255, 255, 0, 0, 0, "trunc2");
    check("trunc2.prod1", int'(prod), 1);

    // Sum wrap and carry-out.
    step(20, 10, 100, 0, 0, "wrap1");
    step(20, 10, 100, 0, 0, "wrap2");
    check("wrap2.sum44", int'(sum), 44);
    check("wrap2.cout1", int'(cout), 1);
    step(20, 10, 0, 0, 0, "wrap3");
    check("wrap3.sum200", int'(sum), 200);
    check("wrap3.cout0", int'(cout), 0);

    // Block hold.
    step(3, 5, 0, 0, 0, "pre_blk");
    step(3, 5, 10, 0, 0, "pre_blk2");
    check("pre_blk2.sum25", int'(sum), 25);
    for (int i = 0; i < 3; i++) step(7, 7, 1, 1, 0, "blk");
    check("blk.prod49", int'(prod), 49);
    check("blk.sum25", int'(sum), 25);
    step(7, 7, 1, 0, 0, "unblk");
    check("unblk.sum50", int'(sum), 50);

    // Reset in the middle of streaming operands.
    for (int i = 0; i < 4; i++)
      step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)), 0, 0, "stream");
    step(123, 45, 67, 0, 1, "midrst");
    check("midrst.sum0", int'(sum), 0);
    step(2, 2, 5, 0, 0, "post1");
    check("post1.sum5", int'(sum), 5);
    step(2, 2, 5, 0, 0, "post2");
    check("post2.sum9", int'(sum), 9);

    // Randomized traffic with occasional reset and frequent block.
    for (int i = 0; i < 400; i++)
      step(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 255)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0), "rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
